// File: rtl/cache_fill_ctrl.sv
// Purpose: arbitrates I/D cache block misses onto one main memory and streams the block back into the missing cache.
// Latency: miss seen in IDLE at T -> reads issued T+1..T+WORDS -> DONE one cycle after the last word returns.
// Backpressure: none from memory; the pipeline is held through the combinational stall outputs until the fill is done.
module cache_fill_ctrl #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data_out,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_wen,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       fill_data,
  output logic              fill_target,
  output logic              tag_wen,
  output logic              fill_done_i,
  output logic              fill_done_d,
  output logic              stall_inst_miss,
  output logic              stall_data_miss
);

  // Byte-offset bits inside a block, and a counter wide enough to hold WORDS_PER_BLOCK itself.
  localparam int OFF_W = $clog2(2 * WORDS_PER_BLOCK);
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [CNT_W-1:0] WORDS     = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  issue_cnt, issue_nxt;
  logic [CNT_W-1:0]  recv_cnt, recv_nxt;
  logic              target, target_nxt;
  logic [ADDR_W-1:0] base, base_nxt;

  // Word address inside the current block; the offset never carries into tag/index bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] blk,
                                                  input logic [CNT_W-1:0]  idx);
    return blk + ADDR_W'({idx[CNT_W-2:0], 1'b0});
  endfunction

  // State and fill bookkeeping registers; reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      target    <= 1'b0;
      base      <= '0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_nxt;
      recv_cnt  <= recv_nxt;
      target    <= target_nxt;
      base      <= base_nxt;
    end
  end

  // Next-state and output decode: D wins arbitration, issue and receive run independently in FILL.
  always_comb begin
    state_nxt   = state;
    issue_nxt   = issue_cnt;
    recv_nxt    = recv_cnt;
    target_nxt  = target;
    base_nxt    = base;
    mem_en      = 1'b0;
    mem_addr    = '0;
    fill_wen    = 1'b0;
    fill_addr   = '0;
    fill_data   = '0;
    tag_wen     = 1'b0;
    fill_done_i = 1'b0;
    fill_done_d = 1'b0;

    case (state)
      IDLE: begin
        issue_nxt = '0;
        recv_nxt  = '0;
        if (dcache_miss) begin
          target_nxt = 1'b1;
          base_nxt   = dcache_miss_addr & BLK_MASK;
          state_nxt  = FILL;
        end else if (icache_miss) begin
          target_nxt = 1'b0;
          base_nxt   = icache_miss_addr & BLK_MASK;
          state_nxt  = FILL;
        end
      end

      FILL: begin
        if (issue_cnt < WORDS) begin
          mem_en    = 1'b1;
          mem_addr  = word_addr(base, issue_cnt);
          issue_nxt = issue_cnt + 1'b1;
        end
        // Only data for a read already issued in this fill is accepted, so returns
        // belonging to a fill killed by reset cannot be mistaken for word 0.
        if (mem_data_valid && (recv_cnt < issue_cnt)) begin
          fill_wen  = 1'b1;
          fill_addr = word_addr(base, recv_cnt);
          fill_data = mem_data_out;
          recv_nxt  = recv_cnt + 1'b1;
          if (recv_cnt == LAST_WORD) begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        tag_wen     = 1'b1;
        fill_done_d = target;
        fill_done_i = ~target;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign fill_target     = target;
  assign stall_inst_miss = icache_miss & ~fill_done_i;
  assign stall_data_miss = dcache_miss & ~fill_done_d;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Purpose: self-checking bench for cache_fill_ctrl with a pipelined memory model and a timeline reference model.
// Latency: memory returns each read a programmable number of cycles after mem_en.
// Backpressure: none; misses are held by the bench until the matching done pulse.
module tb_cache_fill_ctrl;

  localparam int W = 8;
  localparam int M = 4095;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dcache_miss, icache_miss;
  logic [15:0] dcache_miss_addr, icache_miss_addr;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data_out = 16'h0;
  logic        mem_en, fill_wen, fill_target, tag_wen;
  logic [15:0] mem_addr, fill_addr, fill_data;
  logic        fill_done_i, fill_done_d, stall_inst_miss, stall_data_miss;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .fill_wen(fill_wen), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_target(fill_target), .tag_wen(tag_wen),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
    .stall_inst_miss(stall_inst_miss), .stall_data_miss(stall_data_miss)
  );

  typedef struct packed {
    logic        en;
    logic [15:0] ma;
    logic        wen;
    logic [15:0] fa;
    logic [15:0] fd;
    logic        tag;
    logic        di;
    logic        dd;
    logic        si;
    logic        sd;
    logic        tgt;
  } obs_t;

  // in = {rst_n, dcache_miss, icache_miss, mem_data_valid}; ex = {en, wen, tag, di, dd, si, sd}
  typedef struct packed {
    logic [3:0] in;
    logic [6:0] ex;
  } vec_t;

  obs_t        tr [4096];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mem_auto = 1'b0;
  logic        man_valid = 1'b0;
  logic [15:0] man_data = 16'h0;
  int          lat = 4;
  logic        pv [8];
  logic [15:0] pa [8];
  logic        req_v;
  logic [15:0] req_a;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.en = mem_en; o.ma = mem_addr; o.wen = fill_wen; o.fa = fill_addr; o.fd = fill_data;
    o.tag = tag_wen; o.di = fill_done_i; o.dd = fill_done_d;
    o.si = stall_inst_miss; o.sd = stall_data_miss; o.tgt = fill_target;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Trace recorder plus pipelined memory: a read issued in cycle c returns in cycle c+lat.
  always begin
    @(negedge clk);
    tr[cyc & M] = cur_obs();
    req_v = mem_en;
    req_a = mem_addr;
    @(posedge clk);
    #2;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    end else begin
      for (int i = 7; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = req_v;
      pa[0] = req_a;
    end
    if (mem_auto) begin
      mem_data_valid = pv[lat-1];
      mem_data_out   = pv[lat-1] ? mem_fn(pa[lat-1]) : 16'h0;
    end else begin
      mem_data_valid = man_valid;
      mem_data_out   = man_data;
    end
  end

  // Checks a complete fill accepted at cycle t against the expected timeline.
  task automatic check_fill(input int t, input logic [15:0] base, input logic tgt, input int l);
    obs_t o;
    logic [15:0] a;
    for (int k = 0; k < W; k++) begin
      a = base + 16'(2 * k);
      o = tr[(t + 1 + k) & M];
      chk("issue_en", o.en, 1);
      chk("issue_addr", o.ma, a);
    end
    chk("issue_stop", tr[(t + W + 1) & M].en, 0);
    chk("issue_not_early", tr[t & M].en, 0);
    chk("recv_not_early", tr[(t + l) & M].wen, 0);
    chk("target", tr[(t + 1) & M].tgt, tgt);
    for (int r = 0; r < W; r++) begin
      a = base + 16'(2 * r);
      o = tr[(t + l + 1 + r) & M];
      chk("fill_wen", o.wen, 1);
      chk("fill_addr", o.fa, a);
      chk("fill_data", o.fd, mem_fn(a));
      chk("tag_early", o.tag, 0);
    end
    o = tr[(t + l + W + 1) & M];
    chk("tag_wen", o.tag, 1);
    chk("done_sel", tgt ? o.dd : o.di, 1);
    chk("done_other", tgt ? o.di : o.dd, 0);
    chk("stall_drop", tgt ? o.sd : o.si, 0);
    chk("done_no_wen", o.wen, 0);
    chk("tag_single", tr[(t + l + W + 2) & M].tag, 0);
  endtask

  vec_t vt [8];
  obs_t e;
  int   t0, t1, cnt;
  bit   active, pend_d, pend_i, prev_dd, prev_di, mtgt;
  int   mt, d;
  logic [15:0] mbase;

  initial begin
    rst_n = 1'b0;
    dcache_miss = 1'b0; icache_miss = 1'b0;
    dcache_miss_addr = 16'h0; icache_miss_addr = 16'h0;
    repeat (2) tick();

    // Reset and idle behaviour: stalls follow misses, valid in IDLE is ignored.
    vt[0] = '{4'b0000, 7'b0000000};
    vt[1] = '{4'b0101, 7'b0000001};
    vt[2] = '{4'b0011, 7'b0000010};
    vt[3] = '{4'b0110, 7'b0000011};
    vt[4] = '{4'b1001, 7'b0000000};
    vt[5] = '{4'b1001, 7'b0000000};
    vt[6] = '{4'b1000, 7'b0000000};
    vt[7] = '{4'b1000, 7'b0000000};
    for (int i = 0; i < 8; i++) begin
      rst_n = vt[i].in[3]; dcache_miss = vt[i].in[2]; icache_miss = vt[i].in[1];
      man_valid = vt[i].in[0]; man_data = 16'hBEEF;
      @(negedge clk);
      e = '0;
      {e.en, e.wen, e.tag, e.di, e.dd, e.si, e.sd} = vt[i].ex;
      chk($sformatf("vec%0d", i), cur_obs(), e);
      tick();
    end
    man_valid = 1'b0;
    mem_auto  = 1'b1;

    // D miss at 0x1236, latency 4.
    tick(); t0 = cyc;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h1236;
    repeat (14) tick();
    dcache_miss = 1'b0;
    repeat (2) tick();
    check_fill(t0, 16'h1230, 1'b1, 4);
    chk("d_stall_before_done", tr[(t0 + 12) & M].sd, 1);

    // Simultaneous misses: D first, I back-to-back after one idle cycle.
    tick(); t0 = cyc;
    icache_miss = 1'b1; icache_miss_addr = 16'h0040;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h2000;
    repeat (14) tick();
    dcache_miss = 1'b0;
    repeat (14) tick();
    icache_miss = 1'b0;
    repeat (2) tick();
    check_fill(t0, 16'h2000, 1'b1, 4);
    check_fill(t0 + 14, 16'h0040, 1'b0, 4);
    cnt = 0;
    for (int c = t0; c <= t0 + 26; c++) if (!tr[c & M].si) cnt++;
    chk("i_stall_held", cnt, 0);

    // I miss dropped mid-fill at the top of the address space.
    tick(); t0 = cyc;
    icache_miss = 1'b1; icache_miss_addr = 16'hFFF2;
    repeat (3) tick();
    icache_miss = 1'b0;
    repeat (14) tick();
    check_fill(t0, 16'hFFF0, 1'b0, 4);

    // Reset during a D fill, stray return afterwards, then a fresh fill from word 0.
    tick(); t0 = cyc;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h1236;
    repeat (6) tick();
    rst_n = 1'b0; dcache_miss = 1'b0; mem_auto = 1'b0; man_valid = 1'b0;
    tick(); rst_n = 1'b1;
    tick();
    tick(); man_valid = 1'b1; man_data = 16'hDEAD;
    tick(); man_valid = 1'b0; mem_auto = 1'b1;
    t1 = cyc;
    dcache_miss = 1'b1;
    repeat (14) tick();
    dcache_miss = 1'b0;
    repeat (2) tick();
    chk("rst_issue_stop", tr[(t0 + 6) & M].en, 0);
    chk("rst_no_wen", tr[(t0 + 6) & M].wen, 0);
    cnt = 0;
    for (int c = t0 + 6; c <= t0 + 10; c++)
      if (tr[c & M].tag || tr[c & M].dd || tr[c & M].di) cnt++;
    chk("rst_no_done", cnt, 0);
    chk("stray_no_wen", tr[(t0 + 9) & M].wen, 0);
    chk("stray_stays_idle", tr[(t0 + 10) & M].en, 0);
    check_fill(t1, 16'h1230, 1'b1, 4);

    // Random traffic against a timeline model, several memory latencies.
    for (int rnd = 0; rnd < 3; rnd++) begin
      tick();
      rst_n = 1'b0; dcache_miss = 1'b0; icache_miss = 1'b0;
      lat = (rnd == 0) ? 1 : (rnd == 1) ? 3 : 6;
      tick();
      rst_n = 1'b1;
      active = 0; pend_d = 0; pend_i = 0; prev_dd = 0; prev_di = 0; mtgt = 0; mt = 0; mbase = 0;
      for (int n = 0; n < 700; n++) begin
        tick();
        if (pend_d && prev_dd) begin
          dcache_miss = 1'b0; pend_d = 0;
        end else if (!pend_d && $urandom_range(0, 7) == 0) begin
          dcache_miss = 1'b1; dcache_miss_addr = 16'($urandom); pend_d = 1;
        end
        if (pend_i && prev_di) begin
          icache_miss = 1'b0; pend_i = 0;
        end else if (pend_i && $urandom_range(0, 63) == 0) begin
          icache_miss = 1'b0; pend_i = 0;
        end else if (!pend_i && $urandom_range(0, 7) == 0) begin
          icache_miss = 1'b1; icache_miss_addr = 16'($urandom); pend_i = 1;
        end
        @(negedge clk);
        e = '0;
        e.tgt = mtgt;
        d = cyc - mt;
        if (active) begin
          if (d >= 1 && d <= W) begin
            e.en = 1'b1; e.ma = mbase + 16'(2 * (d - 1));
          end
          if (d >= lat + 1 && d <= lat + W) begin
            e.wen = 1'b1; e.fa = mbase + 16'(2 * (d - lat - 1)); e.fd = mem_fn(e.fa);
          end
          if (d == lat + W + 1) begin
            e.tag = 1'b1; e.dd = mtgt; e.di = ~mtgt;
          end
        end
        e.sd = dcache_miss & ~e.dd;
        e.si = icache_miss & ~e.di;
        chk($sformatf("rand_lat%0d", lat), cur_obs(), e);
        prev_dd = e.dd; prev_di = e.di;
        if (active && d == lat + W + 1) begin
          active = 0;
        end else if (!active && (dcache_miss || icache_miss)) begin
          active = 1; mt = cyc; mtgt = dcache_miss;
          mbase = (dcache_miss ? dcache_miss_addr : icache_miss_addr) & 16'hFFF0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
